// File: rtl/optest_pkg.sv
// Shared types, widths and arithmetic helpers for the optest stimulus sweeper.
package optest_pkg;

    localparam int MODE_W = 7;
    localparam int OPND_W = 4;
    localparam int Y_W    = 8;
    localparam int SIG_W  = 16;

    localparam logic [SIG_W-1:0] CRC_POLY      = 16'h1021;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0]      LFSR_TAPS     = 16'hB400;
    localparam logic [15:0]      LFSR_ZERO_SUB = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [SIG_W-1:0] crc16(input logic [SIG_W-1:0] crc,
                                               input logic [Y_W-1:0]   data);
        logic [SIG_W-1:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[SIG_W-1] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/optest_crc16.sv
// Signature register: loads SIG_INIT on init, folds one result byte per fold
// strobe, holds otherwise.
module optest_crc16 import optest_pkg::*; #(
    parameter logic [SIG_W-1:0] SIG_INIT = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_init,
    input  logic             i_fold,
    input  logic [Y_W-1:0]   i_byte,
    output logic [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] r_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= SIG_INIT;
        end else if (i_init) begin
            r_sig <= SIG_INIT;
        end else if (i_fold) begin
            r_sig <= crc16(r_sig, i_byte);
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/optest_sweep.sv
// Stimulus sequencer and CRC-16 response compactor for the optest operator block.
// Define OPTEST_SWEEP_EXHAUSTIVE_EN to sweep all 65536 operand combinations per mode.
module optest_sweep import optest_pkg::*; #(
    parameter int               MODE_MAX = 83,
    parameter int               N_VEC    = 16,
    parameter logic [SIG_W-1:0] SIG_INIT = 16'hFFFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [15:0]              seed,
    output logic [MODE_W-1:0]        mode,
    output logic [OPND_W-1:0]        u1,
    output logic [OPND_W-1:0]        u2,
    output logic signed [OPND_W-1:0] s1,
    output logic signed [OPND_W-1:0] s2,
    input  logic [Y_W-1:0]           y,
    output logic                     busy,
    output logic                     done,
    output logic [SIG_W-1:0]         signature
);

`ifdef OPTEST_SWEEP_EXHAUSTIVE_EN
    localparam int VEC_LAST = 65535;
`else
    localparam int VEC_LAST = N_VEC - 1;
`endif
    localparam logic [15:0]       VEC_LAST_C  = 16'(VEC_LAST);
    localparam logic [MODE_W-1:0] MODE_LAST_C = MODE_W'(MODE_MAX);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_vec_nxt;
    logic [MODE_W-1:0] r_mode_nxt;
    logic              r_vld_p1;
    logic              r_vld_p2;
    logic              r_done;

    logic              w_start_acc;
    logic              w_issue;
    logic              w_last;
    logic              w_fold_last;
    logic [15:0]       w_cur_vec;
    logic [MODE_W-1:0] w_cur_mode;
    logic [15:0]       w_src;

    // A start coinciding with the done pulse is dropped.
    assign w_start_acc = (r_state == IDLE) && start && !r_done;
    assign w_issue     = w_start_acc || (r_state == ISSUE);
    assign w_cur_vec   = w_start_acc ? 16'd0 : r_vec_nxt;
    assign w_cur_mode  = w_start_acc ? '0 : r_mode_nxt;
    assign w_last      = (w_cur_vec == VEC_LAST_C) && (w_cur_mode == MODE_LAST_C);
    assign w_fold_last = r_vld_p2 && !r_vld_p1;

`ifdef OPTEST_SWEEP_EXHAUSTIVE_EN
    assign w_src = w_cur_vec;
`else
    logic [15:0] r_lfsr;
    logic [15:0] w_seed_eff;

    assign w_seed_eff = (seed == 16'd0) ? LFSR_ZERO_SUB : seed;
    assign w_src      = w_start_acc ? w_seed_eff : r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_ZERO_SUB;
        end else if (w_issue) begin
            r_lfsr <= lfsr_next(w_src);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_acc) w_state_nxt = w_last ? DRAIN : ISSUE;
            ISSUE:   if (w_last)      w_state_nxt = DRAIN;
            DRAIN:   if (w_fold_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = r_done;
    end

    // r_vld_p1 marks y about to be registered by the operator block,
    // r_vld_p2 marks y ready to fold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1   <= 1'b0;
            r_vld_p2   <= 1'b0;
            r_done     <= 1'b0;
            r_vec_nxt  <= 16'd0;
            r_mode_nxt <= '0;
            mode       <= '0;
            u1         <= '0;
            u2         <= '0;
            s1         <= '0;
            s2         <= '0;
        end else begin
            r_vld_p1 <= w_issue;
            r_vld_p2 <= r_vld_p1;
            r_done   <= (r_state == DONE);
            if (w_issue) begin
                mode             <= w_cur_mode;
                {u1, u2, s1, s2} <= w_src;
                if (w_cur_vec == VEC_LAST_C) begin
                    r_vec_nxt  <= 16'd0;
                    r_mode_nxt <= w_cur_mode + 1'b1;
                end else begin
                    r_vec_nxt  <= w_cur_vec + 16'd1;
                    r_mode_nxt <= w_cur_mode;
                end
            end
        end
    end

    optest_crc16 #(
        .SIG_INIT (SIG_INIT)
    ) u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_init (w_start_acc),
        .i_fold (r_vld_p2),
        .i_byte (y),
        .o_sig  (signature)
    );

endmodule
